// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word memory with configurable wait states; DMEM_RESP_ALIGN_CHECK_EN enables misaligned-access rejection
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic cap_write, cap_mis;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0] cap_wdata;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic accept, enter_resp, direct, misalign, acc_write, acc_mis;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0] acc_wdata;
  logic unused_addr;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign misalign = |req_addr[1:0];
`else
  assign misalign = 1'b0;
`endif
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
  assign req_ready  = rst && state == IDLE;
  assign rsp_valid  = state == RESP;
  assign accept     = req_valid && req_ready;
  assign enter_resp = (state == WAIT && cnt == 4'd0) || (accept && WAIT_CYCLES == 0);
  assign direct     = state == IDLE;
  assign acc_write  = direct ? req_write : cap_write;
  assign acc_mis    = direct ? misalign : cap_mis;
  assign acc_idx    = direct ? req_addr[DEPTH_LOG2+1:2] : cap_idx;
  assign acc_wdata  = direct ? req_wdata : cap_wdata;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // capture request fields and count wait states; the counter holds cycles remaining after the current one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_mis   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cnt       <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      cap_write <= req_write;
      cap_mis   <= misalign;
      cap_idx   <= req_addr[DEPTH_LOG2+1:2];
      cap_wdata <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  // array storage is never cleared; stores commit on the edge entering RESP
  always_ff @(posedge clk)
    if (enter_resp && acc_write && !acc_mis) mem[acc_idx] <= acc_wdata;
  // response registers, loaded on the edge entering RESP and held until consumed
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (acc_write || acc_mis) ? 32'h0 : mem[acc_idx];
      rsp_err   <= acc_mis;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors for dmem_responder with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
module tb_dmem_responder;
`ifdef DMEM_RESP_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic z_req_valid = 1'b0, z_req_ready, z_req_write = 1'b0, z_rsp_valid, z_rsp_err;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0, z_rsp_rdata;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;
  vec_t v[9];
  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("req_ready in idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid drop", rsp_valid, 0);
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    v[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0};
    v[1] = '{1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0};
    v[2] = '{1'b1, 32'h000, 32'h1234, 32'h0, 1'b0};
    v[3] = '{1'b0, 32'h400, 32'h0, 32'h1234, 1'b0};
    v[4] = '{1'b1, 32'h40,  32'h55AA55AA, 32'h0, 1'b0};
    v[5] = '{1'b1, 32'h42,  32'h0BADF00D, 32'h0, ALN};
    v[6] = '{1'b0, 32'h40,  32'h0, ALN ? 32'h55AA55AA : 32'h0BADF00D, 1'b0};
    v[7] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0};
    v[8] = '{1'b0, 32'h13,  32'h0, ALN ? 32'h0 : 32'hDEADBEEF, ALN};
    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset z_req_ready", z_req_ready, 0);
    rst = 1'b1;
    #1 chk("req_ready after reset", req_ready, 1);
    for (int i = 0; i < 9; i++) begin
      txn(v[i].w, v[i].a, v[i].d, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, v[i].rd);
      chk($sformatf("vec%0d err", i), er, v[i].er);
      chk($sformatf("vec%0d latency", i), lat, 2);
    end
    txn(1'b0, 32'h7FC, 32'h0, rd, er, lat);
    chk("alias top word", rd, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d rsp_valid", k), rsp_valid, 1);
      chk($sformatf("stall%0d rdata", k), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d req_ready", k), req_ready, 0);
      req_valid = k[0]; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall release", rsp_valid, 0);
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("stall pulses ignored", rd, 32'hDEADBEEF);
    txn(1'b1, 32'h30, 32'h11111111, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h22222222;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("wait-reset req_ready", req_ready, 0);
    chk("wait-reset rsp_valid", rsp_valid, 0);
    chk("wait-reset rsp_rdata", rsp_rdata, 0);
    chk("wait-reset rsp_err", rsp_err, 0);
    @(negedge clk);
    chk("wait-reset held rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    #1 chk("wait-reset release req_ready", req_ready, 1);
    txn(1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("aborted store", rd, 32'h11111111);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h34; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("resp-reset pending", rsp_valid, 1);
    rst = 1'b0;
    #1 chk("resp-reset rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 32'h34, 32'h0, rd, er, lat);
    chk("committed store kept", rd, 32'h77);
    @(negedge clk);
    chk("z idle ready", z_req_ready, 1);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h20; z_req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("z store rsp_valid", z_rsp_valid, 1);
    chk("z store rdata", z_rsp_rdata, 0);
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z store rsp_valid drop", z_rsp_valid, 0);
    chk("z store req_ready", z_req_ready, 1);
    z_req_valid = 1'b1; z_req_write = 1'b0;
    @(negedge clk);
    chk("z load rsp_valid", z_rsp_valid, 1);
    chk("z load rdata", z_rsp_rdata, 32'hA5A5A5A5);
    chk("z load req_ready", z_req_ready, 0);
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z load rsp_valid drop", z_rsp_valid, 0);
    chk("z load req_ready back", z_req_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
